// File: rtl/rx_pkg.sv
// Shared receiver definitions: boundary-detector state encoding and symbol compare mask.
package rx_pkg;

    typedef enum logic [1:0] {
        BD_IDLE    = 2'd0,
        BD_HUNT    = 2'd1,
        BD_CONFIRM = 2'd2,
        BD_LOCK    = 2'd3
    } bd_state_t;

    // Bits of the hard symbol that take part in a compare: I only for BPSK, I and Q for QPSK.
    function automatic logic [1:0] sym_mask(input logic qpsk);
        return qpsk ? 2'b11 : 2'b01;
    endfunction

endpackage

// File: rtl/rx_sym_cmp.sv
// Symbol comparator: remembers the previous strobed symbol and classifies the current one
// against it as alternating, repeated or other under a bit mask.
module rx_sym_cmp #(
    parameter int SYM_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    input  logic [SYM_WIDTH-1:0] i_sym,
    input  logic [SYM_WIDTH-1:0] i_mask,
    output logic                 o_alt,
    output logic                 o_rep,
    output logic                 o_other
);

    logic [SYM_WIDTH-1:0] r_prev;
    logic [SYM_WIDTH-1:0] w_diff;

    // Previous symbol follows every strobe, regardless of what the consumer does with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else if (i_vld) begin
            r_prev <= i_sym;
        end
    end

    // Masked difference: all masked bits flipped = alternating, none flipped = repeat.
    always_comb begin
        w_diff  = (i_sym ^ r_prev) & i_mask;
        o_alt   = (w_diff == i_mask);
        o_rep   = (w_diff == '0);
        o_other = !o_alt && !o_rep;
    end

endmodule

// File: rtl/rx_bd_sync.sv
// Boundary detector / frame tracker: finds an alternating preamble ended by a repeated symbol,
// confirms it over a window of alternations, then counts payload symbols before re-arming.
module rx_bd_sync #(
    parameter int SYM_WIDTH        = 2,
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int LEN_WIDTH        = 12,
    parameter int HDR_MIN_ALT      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sym_vld,
    input  logic [SYM_WIDTH-1:0]        sym,
    input  logic                        MODE_QPSK,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic [LEN_WIDTH-1:0]        RX_PKT_LEN,
    input  logic                        PD_flag,
    input  logic                        disassert_BD,
    output logic                        BD_init,
    output logic                        BD_flag,
    output logic [SYM_WIDTH-1:0]        BD_sgn,
    output logic                        pkt_done,
    output logic [1:0]                  bd_state
);

    import rx_pkg::*;

    localparam int ALT_W = $clog2(HDR_MIN_ALT + 1);
    localparam logic [ALT_W-1:0]            ALT_MAX = ALT_W'(HDR_MIN_ALT);
    localparam logic [ALT_W-1:0]            ALT_ONE = ALT_W'(1);
    localparam logic [MAX_WINDOW_WIDTH-1:0] WIN_ONE = MAX_WINDOW_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]        LEN_ONE = LEN_WIDTH'(1);

    bd_state_t                   r_state;
    logic [ALT_W-1:0]            r_alt_cnt;
    logic [MAX_WINDOW_WIDTH-1:0] r_win_cnt;
    logic [LEN_WIDTH-1:0]        r_len_cnt;
    logic [LEN_WIDTH-1:0]        r_pkt_len;
    logic                        r_bd_init;
    logic                        r_bd_flag;
    logic [SYM_WIDTH-1:0]        r_bd_sgn;
    logic                        r_pkt_done;

    logic [SYM_WIDTH-1:0]        w_mask;
    logic [MAX_WINDOW_WIDTH-1:0] w_win_tgt;
    logic                        w_alt;
    logic                        w_rep;
    logic                        w_other;

    // Compare mask and effective window length (a zero window behaves as one beat).
    always_comb begin
        w_mask    = SYM_WIDTH'(sym_mask(MODE_QPSK));
        w_win_tgt = (RX_BD_WINDOW == '0) ? WIN_ONE : RX_BD_WINDOW;
    end

    rx_sym_cmp #(
        .SYM_WIDTH (SYM_WIDTH)
    ) u_sym_cmp (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (sym_vld),
        .i_sym   (sym),
        .i_mask  (w_mask),
        .o_alt   (w_alt),
        .o_rep   (w_rep),
        .o_other (w_other)
    );

    // Boundary FSM with counters and registered outputs; loss of lock or release wins over it.
    always_ff @(posedge clk) begin
        if (rst || !PD_flag || disassert_BD) begin
            r_state    <= BD_IDLE;
            r_alt_cnt  <= '0;
            r_win_cnt  <= '0;
            r_len_cnt  <= '0;
            r_pkt_len  <= '0;
            r_bd_init  <= 1'b0;
            r_bd_flag  <= 1'b0;
            r_bd_sgn   <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_bd_init  <= 1'b0;
            r_pkt_done <= 1'b0;
            unique case (r_state)
                BD_IDLE: begin
                    r_state <= BD_HUNT;
                end
                BD_HUNT: begin
                    if (sym_vld) begin
                        if (w_alt) begin
                            if (r_alt_cnt < ALT_MAX) begin
                                r_alt_cnt <= r_alt_cnt + ALT_ONE;
                            end
                        end else if (w_other || r_alt_cnt < ALT_MAX) begin
                            r_alt_cnt <= '0;
                        end else begin
                            r_state   <= BD_CONFIRM;
                            r_bd_init <= 1'b1;
                            r_bd_sgn  <= sym & w_mask;
                            r_win_cnt <= '0;
                        end
                    end
                end
                BD_CONFIRM: begin
                    if (sym_vld) begin
                        if (!w_alt) begin
                            // Bad window: hunt again, keep the now-stale sign reference.
                            r_state   <= BD_HUNT;
                            r_alt_cnt <= '0;
                        end else if (r_win_cnt + WIN_ONE == w_win_tgt) begin
                            r_state   <= BD_LOCK;
                            r_bd_flag <= 1'b1;
                            r_len_cnt <= '0;
                            r_pkt_len <= RX_PKT_LEN;
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_ONE;
                        end
                    end
                end
                BD_LOCK: begin
                    // Zero length means hold the lock until released externally.
                    if (sym_vld && r_pkt_len != '0) begin
                        if (r_len_cnt + LEN_ONE == r_pkt_len) begin
                            r_state    <= BD_HUNT;
                            r_pkt_done <= 1'b1;
                            r_bd_flag  <= 1'b0;
                            r_alt_cnt  <= '0;
                            r_len_cnt  <= '0;
                        end else begin
                            r_len_cnt <= r_len_cnt + LEN_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= BD_IDLE;
                end
            endcase
        end
    end

    assign BD_init  = r_bd_init;
    assign BD_flag  = r_bd_flag;
    assign BD_sgn   = r_bd_sgn;
    assign pkt_done = r_pkt_done;
    assign bd_state = r_state;

endmodule

// File: tb/tb_rx_bd_sync.sv
// Bench for rx_bd_sync: directed header scenarios plus random packets, checked by a scoreboard
// of expected output events (init pulse, flag rise/fall, done pulse) with their clock cycle.
module tb_rx_bd_sync;

    localparam int HMA = 4;
    localparam int EV_INIT = 0, EV_RISE = 1, EV_DONE = 2, EV_FALL = 3;
    localparam int PH_HUNT = 0, PH_CONF = 1, PH_LOCK = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] sgn;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sym_vld = 1'b0;
    logic [1:0]  sym = 2'b00;
    logic        MODE_QPSK = 1'b0;
    logic [7:0]  RX_BD_WINDOW = 8'd4;
    logic [11:0] RX_PKT_LEN = 12'd8;
    logic        PD_flag = 1'b1;
    logic        disassert_BD = 1'b0;
    logic        BD_init, BD_flag, pkt_done;
    logic [1:0]  BD_sgn, bd_state;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    logic flag_q = 1'b0;
    ev_t  exp_q[$];

    // Reference model: protocol phase, unbounded counts, last strobed symbol.
    int         m_phase = PH_HUNT;
    int         m_alts = 0;
    int         m_wins = 0;
    int         m_pay = 0;
    int         m_tgt = 0;
    logic [1:0] m_prev = 2'b00;

    rx_bd_sync dut (
        .clk          (clk),
        .rst          (rst),
        .sym_vld      (sym_vld),
        .sym          (sym),
        .MODE_QPSK    (MODE_QPSK),
        .RX_BD_WINDOW (RX_BD_WINDOW),
        .RX_PKT_LEN   (RX_PKT_LEN),
        .PD_flag      (PD_flag),
        .disassert_BD (disassert_BD),
        .BD_init      (BD_init),
        .BD_flag      (BD_flag),
        .BD_sgn       (BD_sgn),
        .pkt_done     (pkt_done),
        .bd_state     (bd_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected events appear in the clock after the beat being driven now.
    task automatic push(input int kind, input logic [1:0] sgn);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc + 1;
        e.sgn  = sgn;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [1:0] sgn);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == EV_INIT && e.sgn != sgn)) begin
                failures++;
                $display("FAIL event: got kind %0d cyc %0d sgn %0d, expected kind %0d cyc %0d sgn %0d",
                         kind, cyc, sgn, e.kind, e.cyc, e.sgn);
            end
        end
    endtask

    // Monitor: turn output activity into events and check them against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (BD_init) observe(EV_INIT, BD_sgn);
            if (BD_flag && !flag_q) observe(EV_RISE, 2'b00);
            if (pkt_done) observe(EV_DONE, 2'b00);
            if (!BD_flag && flag_q) observe(EV_FALL, 2'b00);
            flag_q = BD_flag;
        end
    end

    task automatic model_beat(input logic [1:0] s);
        logic [1:0] lm, d;
        int         win;
        lm     = MODE_QPSK ? 2'b11 : 2'b01;
        d      = (s ^ m_prev) & lm;
        m_prev = s;
        win    = (RX_BD_WINDOW == 8'd0) ? 1 : int'(RX_BD_WINDOW);
        case (m_phase)
            PH_HUNT: begin
                if (d == lm) m_alts++;
                else if (d == 2'b00 && m_alts >= HMA) begin
                    push(EV_INIT, s & lm);
                    m_phase = PH_CONF;
                    m_wins  = 0;
                end else m_alts = 0;
            end
            PH_CONF: begin
                if (d == lm) begin
                    m_wins++;
                    if (m_wins >= win) begin
                        push(EV_RISE, 2'b00);
                        m_phase = PH_LOCK;
                        m_pay   = 0;
                        m_tgt   = int'(RX_PKT_LEN);
                    end
                end else begin
                    m_phase = PH_HUNT;
                    m_alts  = 0;
                end
            end
            default: begin
                m_pay++;
                if (m_tgt != 0 && m_pay == m_tgt) begin
                    push(EV_DONE, 2'b00);
                    push(EV_FALL, 2'b00);
                    m_phase = PH_HUNT;
                    m_alts  = 0;
                end
            end
        endcase
    endtask

    task automatic beat(input logic [1:0] s, input int gap);
        sym_vld = 1'b1;
        sym     = s;
        model_beat(s);
        @(posedge clk); #1;
        sym_vld = 1'b0;
        sym     = 2'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic alt_beats(input int n, input int gap);
        logic [1:0] s;
        for (int i = 0; i < n; i++) begin
            s = m_prev ^ (MODE_QPSK ? 2'b11 : 2'b01);
            if (!MODE_QPSK) s[1] = 1'($urandom);
            beat(s, gap);
        end
    endtask

    task automatic rep_beat(input int gap);
        logic [1:0] s;
        s = m_prev;
        if (!MODE_QPSK) s[1] = 1'($urandom);
        beat(s, gap);
    endtask

    task automatic rand_beats(input int n, input int gap);
        for (int i = 0; i < n; i++) beat(2'($urandom), gap);
    endtask

    // Force IDLE through PD_flag or disassert_BD, optionally re-program the mode, then re-arm.
    task automatic abort(input bit use_pd, input bit qpsk, input int win);
        if (m_phase == PH_LOCK) push(EV_FALL, 2'b00);
        if (use_pd) PD_flag = 1'b0;
        else disassert_BD = 1'b1;
        @(posedge clk); #1;
        check("abort_state", bd_state, 0);
        check("abort_flag", BD_flag, 0);
        check("abort_sgn", BD_sgn, 0);
        check("abort_pulses", {BD_init, pkt_done}, 0);
        PD_flag      = 1'b0;
        disassert_BD = 1'b0;
        MODE_QPSK    = qpsk;
        RX_BD_WINDOW = 8'(win);
        @(posedge clk); #1;
        PD_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_phase = PH_HUNT;
        m_alts  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_bd_init", BD_init, 0);
        check("reset_bd_flag", BD_flag, 0);
        check("reset_bd_sgn", BD_sgn, 0);
        check("reset_pkt_done", pkt_done, 0);
        check("reset_state", bd_state, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hunt_after_reset", bd_state, 1);

        // BPSK, window 4, length 8, continuous strobe.
        alt_beats(5, 0);
        rep_beat(0);
        check("bpsk_init", BD_init, 1);
        check("bpsk_sgn", BD_sgn, 1);
        check("bpsk_confirm_state", bd_state, 2);
        alt_beats(4, 0);
        check("bpsk_flag_rise", BD_flag, 1);
        check("bpsk_lock_state", bd_state, 3);
        rand_beats(8, 0);
        check("bpsk_pkt_done", pkt_done, 1);
        check("bpsk_flag_fall", BD_flag, 0);
        check("bpsk_rearm_state", bd_state, 1);

        // Same header with a 1-in-4 strobe.
        alt_beats(5, 3);
        rep_beat(3);
        alt_beats(4, 3);
        rand_beats(8, 3);

        // Short preamble must not give a boundary; a later full header locks.
        alt_beats(3, 0);
        rep_beat(0);
        check("short_no_init", BD_init, 0);
        check("short_still_hunt", bd_state, 1);
        alt_beats(4, 1);
        rep_beat(1);
        alt_beats(4, 1);
        rand_beats(8, 1);

        // Bad window: repeat at the second window beat.
        alt_beats(4, 0);
        rep_beat(0);
        alt_beats(1, 0);
        rep_beat(0);
        check("badwin_hunt", bd_state, 1);
        check("badwin_no_flag", BD_flag, 0);
        alt_beats(4, 2);
        rep_beat(2);
        alt_beats(4, 2);
        rand_beats(8, 2);

        // QPSK, window 3.
        abort(1'b0, 1'b1, 3);
        RX_PKT_LEN = 12'd5;
        beat(2'b00, 0); beat(2'b11, 0); beat(2'b00, 0);
        beat(2'b11, 0); beat(2'b00, 0); beat(2'b00, 0);
        check("qpsk_init", BD_init, 1);
        check("qpsk_sgn", BD_sgn, 0);
        beat(2'b11, 0); beat(2'b00, 0); beat(2'b11, 0);
        check("qpsk_flag", BD_flag, 1);
        rand_beats(5, 0);
        alt_beats(3, 0);
        beat(m_prev ^ 2'b01, 0);
        alt_beats(3, 0);
        rep_beat(0);
        check("qpsk_other_resets", BD_init, 0);
        alt_beats(4, 1);
        rep_beat(1);
        alt_beats(3, 1);
        rand_beats(5, 1);

        // Zero length holds the lock; PD_flag drop and disassert_BD release it.
        abort(1'b1, 1'b0, 4);
        RX_PKT_LEN = 12'd0;
        alt_beats(4, 0);
        rep_beat(0);
        alt_beats(4, 0);
        rand_beats(20, 1);
        check("len0_held", BD_flag, 1);
        abort(1'b1, 1'b0, 2);
        alt_beats(4, 0);
        rep_beat(0);
        alt_beats(2, 0);
        rand_beats(6, 0);
        abort(1'b0, 1'b0, 4);

        // Synchronous reset mid-CONFIRM.
        RX_PKT_LEN = 12'd6;
        alt_beats(4, 0);
        rep_beat(0);
        alt_beats(1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_state", bd_state, 0);
        check("rst_mid_sgn", BD_sgn, 0);
        check("rst_mid_flag", BD_flag, 0);
        rst     = 1'b0;
        m_prev  = 2'b00;
        m_phase = PH_HUNT;
        m_alts  = 0;
        repeat (2) @(posedge clk);
        #1;

        // Random packets with noise, gaps, window/length variety and occasional aborts.
        for (int p = 0; p < 30; p++) begin
            int g;
            if ($urandom_range(0, 3) == 0) begin
                abort(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
            end
            RX_PKT_LEN = 12'($urandom_range(1, 12));
            g = int'($urandom_range(0, 2));
            alt_beats(int'($urandom_range(2, 6)), g);
            if ($urandom_range(0, 4) != 0) rep_beat(g);
            else rand_beats(1, g);
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 9) == 0) rand_beats(1, g);
                else alt_beats(1, g);
            end
            rand_beats(int'($urandom_range(0, 14)), g);
        end

        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
